// File: rtl/pkt_fifo_ctrl_pkg.sv
// Shared encodings for the packet buffer controller: FSM states,
// CPU address regions and register offsets.
package pkt_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  localparam logic [1:0] REGION_BUF = 2'b10;
  localparam logic [1:0] REGION_REG = 2'b11;

  localparam logic [2:0] REG_CPU_DONE   = 3'd0;
  localparam logic [2:0] REG_STATUS     = 3'd1;
  localparam logic [2:0] REG_HEAD       = 3'd2;
  localparam logic [2:0] REG_TAIL       = 3'd3;
  localparam logic [2:0] REG_PKT_CNT    = 3'd4;
  localparam logic [2:0] REG_DROP_CNT   = 3'd5;
  localparam logic [2:0] REG_CONTROL    = 3'd6;
  localparam logic [2:0] REG_CTRL_LATCH = 3'd7;

endpackage

// File: rtl/pkt_fifo_ctrl_buf_ram.sv
// Simple dual-port packet RAM: one write port, one read port with a
// registered (1-cycle) read. Contents are not reset.
module pkt_buf_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 72
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);

  logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pkt_fifo_ctrl.sv
// Single-packet store-and-forward buffer with CPU register window.
// Packet is captured, held for the CPU (or bypassed), then streamed out.
module pkt_fifo_ctrl
  import pkt_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH/8,
  parameter int BUF_ADDR_WIDTH = 8,
  parameter int CPU_ADDR_WIDTH = BUF_ADDR_WIDTH+2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  input  logic                      in_wr,
  output logic                      in_rdy,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic                      out_wr,
  input  logic                      out_rdy,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_in_addr,
  input  logic [63:0]               cpu_in_data,
  input  logic                      cpu_in_wen,
  output logic [63:0]               cpu_out_data
);

  localparam int PW = BUF_ADDR_WIDTH + 1;
  localparam int WW = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};

  state_t                    state;
  logic [PW-1:0]             head, tail;
  logic [31:0]               pkt_cnt, drop_cnt;
  logic                      bypass, seen_zero, buf_rd_q;
  logic [CTRL_WIDTH-1:0]     ctrl_latch;
  logic [63:0]               cpu_reg_q, reg_rd_val;
  logic [WW-1:0]             ram_rd_data;

  function automatic logic [PW-1:0] sat_ptr(input logic [63:0] v);
    return (v > 64'(DEPTH_P)) ? DEPTH_P : v[PW-1:0];
  endfunction

  logic [1:0]                region;
  logic [2:0]                reg_sel;
  logic [BUF_ADDR_WIDTH-1:0] buf_idx;
  logic acc, is_eop, hold, cpu_reg_wr;
  logic fill_wr, cpu_buf_wr, drain_rd, cpu_buf_rd;

  assign region     = cpu_in_addr[CPU_ADDR_WIDTH-1 -: 2];
  assign reg_sel    = cpu_in_addr[2:0];
  assign buf_idx    = cpu_in_addr[BUF_ADDR_WIDTH-1:0];
  assign hold       = (state == ST_HOLD);
  assign acc        = in_wr && in_rdy;
  // EOP: a non-zero ctrl word that follows a zero-ctrl word of the same packet
  assign is_eop     = acc && (in_ctrl != '0) && seen_zero;
  assign cpu_reg_wr = cpu_in_wen && (region == REGION_REG);
  assign fill_wr    = (state == ST_FILL) && acc && (tail < DEPTH_P);
  assign cpu_buf_wr = hold && cpu_in_wen && (region == REGION_BUF);
  assign drain_rd   = (state == ST_DRAIN) && (head < tail) && out_rdy;
  assign cpu_buf_rd = hold && !cpu_in_wen && (region == REGION_BUF);

  pkt_buf_ram #(.ADDR_WIDTH(BUF_ADDR_WIDTH), .WORD_WIDTH(WW)) u_ram (
    .clk     (clk),
    .wr_en   (fill_wr || cpu_buf_wr),
    .wr_addr (fill_wr ? tail[BUF_ADDR_WIDTH-1:0] : buf_idx),
    .wr_data (fill_wr ? {in_ctrl, in_data} : {ctrl_latch, cpu_in_data[DATA_WIDTH-1:0]}),
    .rd_en   (drain_rd || cpu_buf_rd),
    .rd_addr (drain_rd ? head[BUF_ADDR_WIDTH-1:0] : buf_idx),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    reg_rd_val = '0;
    case (reg_sel)
      REG_STATUS:     reg_rd_val = 64'({state, hold});
      REG_HEAD:       reg_rd_val = 64'(head);
      REG_TAIL:       reg_rd_val = 64'(tail);
      REG_PKT_CNT:    reg_rd_val = 64'(pkt_cnt);
      REG_DROP_CNT:   reg_rd_val = 64'(drop_cnt);
      REG_CONTROL:    reg_rd_val = 64'(bypass);
      // forward a latch load that is landing this very cycle
      REG_CTRL_LATCH: reg_rd_val = 64'(buf_rd_q ? ram_rd_data[WW-1:DATA_WIDTH] : ctrl_latch);
      default:        reg_rd_val = '0;
    endcase
  end

  assign out_data     = out_wr ? ram_rd_data[DATA_WIDTH-1:0] : '0;
  assign out_ctrl     = out_wr ? ram_rd_data[WW-1:DATA_WIDTH] : '0;
  assign cpu_out_data = buf_rd_q ? 64'(ram_rd_data[DATA_WIDTH-1:0]) : cpu_reg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      head       <= '0;
      tail       <= '0;
      pkt_cnt    <= '0;
      drop_cnt   <= '0;
      bypass     <= 1'b0;
      ctrl_latch <= '0;
      seen_zero  <= 1'b0;
      in_rdy     <= 1'b0;
      out_wr     <= 1'b0;
      buf_rd_q   <= 1'b0;
      cpu_reg_q  <= '0;
    end else begin
      out_wr    <= drain_rd;
      buf_rd_q  <= cpu_buf_rd;
      cpu_reg_q <= (!cpu_in_wen && region == REGION_REG) ? reg_rd_val : '0;
      in_rdy    <= (state == ST_FILL) || (state == ST_DISCARD);

      if (acc) begin
        if (in_ctrl == '0) seen_zero <= 1'b1;
        else if (seen_zero) seen_zero <= 1'b0;
      end

      if (buf_rd_q) ctrl_latch <= ram_rd_data[WW-1:DATA_WIDTH];
      if (cpu_reg_wr && reg_sel == REG_CTRL_LATCH) ctrl_latch <= cpu_in_data[CTRL_WIDTH-1:0];
      if (cpu_reg_wr && reg_sel == REG_CONTROL) bypass <= cpu_in_data[0];

      case (state)
        ST_FILL: if (acc) begin
          if (tail == DEPTH_P) begin
            drop_cnt <= drop_cnt + 32'd1;
            if (is_eop) tail <= '0;
            else state <= ST_DISCARD;
          end else begin
            tail <= tail + PW'(1);
            if (is_eop) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              state   <= bypass ? ST_DRAIN : ST_HOLD;
              in_rdy  <= 1'b0;
            end
          end
        end
        ST_DISCARD: if (is_eop) begin
          tail  <= '0;
          state <= ST_FILL;
        end
        ST_HOLD: if (cpu_reg_wr) begin
          case (reg_sel)
            REG_CPU_DONE: state <= ST_DRAIN;
            REG_HEAD:     head  <= sat_ptr(cpu_in_data);
            REG_TAIL:     tail  <= sat_ptr(cpu_in_data);
            default: ;
          endcase
        end
        ST_DRAIN: begin
          if (head < tail) begin
            if (out_rdy) head <= head + PW'(1);
          end else begin
            head   <= '0;
            tail   <= '0;
            state  <= ST_FILL;
            in_rdy <= 1'b1;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: doc/pkt_fifo_ctrl.md
# pkt_fifo_ctrl

Parametrised single-packet store-and-forward buffer for the user data path. It captures one packet from the upstream module into an internal buffer and holds it for CPU inspection or modification through the register window. It then streams the packet downstream. Compared with the first-generation controller it adds:

- configurable depth
- writable ctrl bytes and writable head/tail pointers
- overflow drop with counters
- a bypass mode that forwards packets without waiting for the CPU

## Interface

Parameters:

- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- BUF_ADDR_WIDTH, 8, log2 of buffer depth; DEPTH = 2**BUF_ADDR_WIDTH words.
- CPU_ADDR_WIDTH, BUF_ADDR_WIDTH+2, width of cpu_in_addr.

Ports:

- Clock and reset: one clock; reset is asynchronous and active-high. Names are `clk` and `reset`.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in_data  in  DATA_WIDTH  upstream word.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl byte.
- in_wr  in  1  upstream write strobe.
- in_rdy  out  1  block accepts a word this cycle.
- out_data  out  DATA_WIDTH  downstream word.
- out_ctrl  out  CTRL_WIDTH  downstream ctrl byte.
- out_wr  out  1  downstream write strobe.
- out_rdy  in  1  downstream can accept.
- cpu_in_addr  in  CPU_ADDR_WIDTH  register/buffer address.
- cpu_in_data  in  64  CPU write data.
- cpu_in_wen  in  1  CPU write enable.
- cpu_out_data  out  64  CPU read data (registered).

## Operation

States: FILL, HOLD, DRAIN, DISCARD.

- **Packet boundaries.** A packet ends on the first word with in_ctrl != 0 that follows a word with in_ctrl == 0 (EOP).
- **FILL.**
  - in_rdy = 1.
  - Each in_wr writes {in_ctrl, in_data} at tail, then tail++.
  - On the EOP word, pkt_cnt++. Next state is DRAIN if bypass = 1, otherwise HOLD.
  - A word arriving with tail == DEPTH causes overflow: drop_cnt++ and go to DISCARD.
- **DISCARD.**
  - in_rdy = 1; words are consumed and not stored.
  - On EOP: tail = 0, then FILL.
- **HOLD.**
  - in_rdy = 0.
  - The CPU may read/write buffer words and write head/tail.
  - A write to CPU_DONE moves to DRAIN.
- **DRAIN.**
  - in_rdy = 0.
  - While out_rdy = 1 and head < tail: read word at head, head++.
  - The word appears with out_wr = 1 on the next cycle.
  - When head == tail and no read is outstanding: head = tail = 0, then FILL.
- **Address map.** cpu_in_addr top two bits select the region.
  - 2'b10: buffer window, word index = low BUF_ADDR_WIDTH bits.
    - Write stores {ctrl_latch, cpu_in_data}.
    - Read returns the data field.
  - 2'b11: registers, selected by low 3 bits:
    - 0 CPU_DONE (write only).
    - 1 STATUS (read): {state[1:0], packet_rdy}; packet_rdy = (state == HOLD).
    - 2 HEAD (read/write).
    - 3 TAIL (read/write).
    - 4 PKT_CNT (read, 32-bit).
    - 5 DROP_CNT (read, 32-bit).
    - 6 CONTROL (read/write): bit0 bypass.
    - 7 CTRL_LATCH (read/write, low CTRL_WIDTH bits).
    - A buffer read also loads the word's ctrl field into CTRL_LATCH.
- **Access rules.**
  - Buffer and HEAD/TAIL writes are honoured only in HOLD; otherwise ignored.
  - A HEAD/TAIL write value > DEPTH saturates to DEPTH.
  - A buffer read outside HOLD returns 0.
  - CPU_DONE outside HOLD is ignored.
  - CONTROL and CTRL_LATCH are writable in any state.
- **Counters.** Counters wrap at 2^32.

## Timing

- Reset values:
  - in_rdy = 0 during reset; 1 on the first cycle after release.
  - out_wr = 0, out_data = 0, out_ctrl = 0.
  - cpu_out_data = 0.
  - State FILL; head = tail = 0; all counters, bypass and ctrl_latch = 0.
- Buffer contents are undefined after reset. A reset during DRAIN aborts the packet mid-stream.
- cpu_out_data reflects the address sampled in the previous cycle (1-cycle read latency). It is 0 in the cycle after a write.
- Input-to-output latency in bypass mode:
  - EOP accepted in cycle N.
  - DRAIN entered in N+1.
  - First out_wr in N+2 if out_rdy = 1.
- Downstream back-pressure: the block issues a read only when out_rdy = 1. One word may appear in the cycle after out_rdy falls; downstream must absorb it.
- A HEAD == TAIL packet (CPU-emptied) in DRAIN emits no words and returns to FILL after 1 cycle.
- head/tail are BUF_ADDR_WIDTH+1 bits wide.

## Structure

- A shared package holds:
  - state encoding (FILL = 0, HOLD = 1, DRAIN = 2, DISCARD = 3)
  - region codes 2'b10/2'b11
  - register offsets 0–7
- One sub-module, `pkt_buf_ram`: simple dual-port RAM, DEPTH × (CTRL_WIDTH + DATA_WIDTH), 1-cycle registered read. Port A is written by FILL or CPU; port B is read by DRAIN or CPU.
- The controller FSM, pointers, counters and register decode live in `pkt_fifo_ctrl`.

## Test plan

- **Store and release.** Send 5-word packet, ctrl 0xFF,0,0,0,0x10, bypass = 0. Expect:
  - STATUS reads 3 (HOLD, packet_rdy = 1).
  - TAIL reads 5.
  - After CPU_DONE, 5 words out in order, identical.
  - PKT_CNT = 1.
- **CPU modify.** In HOLD:
  - Write CTRL_LATCH = 0x20, then buffer word 4 = 0xDEAD.
  - Write TAIL = 4, then CPU_DONE.
  - Expect 4 words out; word 3 unchanged; word 4 never emitted.
  - Repeat with TAIL = 5: word 4 = {0x20, 0xDEAD}.
- **Bypass.** CONTROL = 1, send 3-word packet with out_rdy = 1. Expect first out_wr exactly 2 cycles after EOP and no HOLD state.
- **Overflow.** BUF_ADDR_WIDTH = 4, send a 20-word packet, then a 3-word packet. Expect:
  - DROP_CNT = 1 and no output for the first packet.
  - The second packet is held with TAIL = 3.
- **Back-pressure.** Toggle out_rdy 1,0,0,1 during an 8-word drain. Expect all 8 words, no duplicates, and at most one word after each out_rdy fall.
- **Reset and access checks.**
  - Assert reset mid-DRAIN: expect out_wr = 0 immediately and in_rdy = 1 after release.
  - Buffer write in FILL has no effect.
  - CPU_DONE in FILL is ignored.
